// File: rtl/class_decision.sv
// class_decision: picks the winning class from a 4-score frame and reports a
// saturated top-1/top-2 confidence margin.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   score_valid/ready   handshake for one signed 16-bit score per transfer
//   score_data          class score, arriving in class order 0..3
//   score_last          must be set on the 4th score of a frame, and only there
//   conf_shift          right shift applied to the margin (sampled in RESOLVE)
//   classification_done one-cycle pulse, class_id/confidence valid
//   class_id            index of the winning class
//   confidence          (max - second) >> conf_shift, saturated to 255
//   frame_err           one-cycle pulse, malformed frame discarded
//   busy                frame partially received or being resolved
//
// Optional feature: define DECISION_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES idle cycles.
module class_decision #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic signed [15:0] score_data,
    input  logic               score_last,
    input  logic [1:0]         conf_shift,
    output logic               classification_done,
    output logic [1:0]         class_id,
    output logic [7:0]         confidence,
    output logic               frame_err,
    output logic               busy
);

    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned MARGIN_W = 17;
    localparam int unsigned CONF_W   = 8;
    localparam int unsigned IDX_W    = 2;
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = 16'sh8000;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

    // Parameter sanity: the idle counter is 8 bits wide.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [SCORE_W-1:0] max_q, max_d;
    logic signed [SCORE_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]          best_q, best_d;
    logic [IDX_W-1:0]          class_id_d;
    logic [CONF_W-1:0]         confidence_d;
    logic                      done_d;
    logic                      err_d;
    logic                      ready_d;
    logic                      busy_d;
    logic                      xfer;
    logic                      bad_frame;
    logic [MARGIN_W-1:0]       margin;
    logic [MARGIN_W-1:0]       shifted;

`ifdef DECISION_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] idle_q, idle_d;
`endif

    // A score is consumed whenever valid meets ready.
    assign xfer = score_valid && score_ready;

    // score_last must coincide exactly with the 4th score.
    assign bad_frame = score_last != (idx_q == LAST_IDX);

    // Next-state, tracker update and resolve arithmetic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        max_d        = max_q;
        second_d     = second_q;
        best_d       = best_q;
        class_id_d   = class_id;
        confidence_d = confidence;
        done_d       = 1'b0;
        err_d        = 1'b0;
        margin       = '0;
        shifted      = '0;
`ifdef DECISION_TIMEOUT_EN
        idle_d       = '0;
`endif

        case (state_q)
            ACCUM: begin
                if (xfer) begin
                    if (bad_frame) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        if (idx_q == '0) begin
                            max_d    = score_data;
                            second_d = SCORE_MIN;
                            best_d   = '0;
                        end else if (score_data > max_q) begin
                            second_d = max_q;
                            max_d    = score_data;
                            best_d   = idx_q;
                        end else if (score_data > second_q) begin
                            second_d = score_data;
                        end
                        idx_d = IDX_W'(idx_q + 2'd1);
                        if (idx_q == LAST_IDX) begin
                            state_d = RESOLVE;
                        end
                    end
`ifdef DECISION_TIMEOUT_EN
                end else if (idx_q != '0) begin
                    // Idle mid-frame: abort once the limit is reached.
                    if (idle_q == IDLE_LIMIT) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idle_d = CNT_W'(idle_q + 8'd1);
                    end
`endif
                end
            end
            RESOLVE: begin
                // max >= second always holds, so the 17-bit difference is non-negative.
                margin  = MARGIN_W'($signed({max_q[SCORE_W-1], max_q}) -
                                    $signed({second_q[SCORE_W-1], second_q}));
                shifted = margin >> conf_shift;
                confidence_d = (shifted > 17'd255) ? 8'hFF : shifted[CONF_W-1:0];
                class_id_d   = best_q;
                state_d      = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                idx_d   = '0;
                state_d = ACCUM;
            end
            default: begin
                idx_d   = '0;
                state_d = ACCUM;
            end
        endcase

        ready_d = (state_d == ACCUM);
        busy_d  = (idx_d != '0) || (state_d != ACCUM);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= ACCUM;
            idx_q               <= '0;
            max_q               <= '0;
            second_q            <= '0;
            best_q              <= '0;
            class_id            <= '0;
            confidence          <= '0;
            classification_done <= 1'b0;
            frame_err           <= 1'b0;
            score_ready         <= 1'b0;
            busy                <= 1'b0;
        end else begin
            state_q             <= state_d;
            idx_q               <= idx_d;
            max_q               <= max_d;
            second_q            <= second_d;
            best_q              <= best_d;
            class_id            <= class_id_d;
            confidence          <= confidence_d;
            classification_done <= done_d;
            frame_err           <= err_d;
            score_ready         <= ready_d;
            busy                <= busy_d;
        end
    end

`ifdef DECISION_TIMEOUT_EN
    // Idle counter for partial frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

endmodule

// File: tb/tb_class_decision.sv
module tb_class_decision;

`ifdef DECISION_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 10;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               score_valid;
    logic               score_ready;
    logic signed [15:0] score_data;
    logic               score_last;
    logic [1:0]         conf_shift;
    logic               classification_done;
    logic [1:0]         class_id;
    logic [7:0]         confidence;
    logic               frame_err;
    logic               busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_id = 0;
    int last_conf = 0;
    int done_times[$];

    typedef struct {
        int s0, s1, s2, s3;
        int sh;
        int id;
        int conf;
    } vec_t;

    vec_t tbl[8];

    class_decision #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .score_valid         (score_valid),
        .score_ready         (score_ready),
        .score_data          (score_data),
        .score_last          (score_last),
        .conf_shift          (conf_shift),
        .classification_done (classification_done),
        .class_id            (class_id),
        .confidence          (confidence),
        .frame_err           (frame_err),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (classification_done) done_times.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: winner is the first index holding the maximum; runner-up is
    // the largest score among the other three classes.
    function automatic void model(input int s[4], input int sh, output int id, output int conf);
        int best = 0;
        int sec = -100000;
        int m;
        for (int i = 1; i < 4; i++) if (s[i] > s[best]) best = i;
        for (int i = 0; i < 4; i++) if (i != best && s[i] > sec) sec = s[i];
        m = (s[best] - sec) >>> sh;
        id = best;
        conf = (m > 255) ? 255 : m;
    endfunction

    task automatic xfer(input int d, input logic last);
        int n = 0;
        score_valid = 1'b1;
        score_data  = 16'(d);
        score_last  = last;
        while (!score_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!score_ready) check("ready_wait_timeout", 0, 1);
        @(posedge clk); #1;
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                             input int sh, input int eid, input int econf);
        conf_shift = 2'(sh);
        xfer(s0, 1'b0);
        xfer(s1, 1'b0);
        xfer(s2, 1'b0);
        xfer(s3, 1'b1);
        check("done_early_e0", int'(classification_done), 0);
        check("busy_after_last", int'(busy), 1);
        @(posedge clk); #1;
        check("done_early_e1", int'(classification_done), 0);
        @(posedge clk); #1;
        check("done", int'(classification_done), 1);
        check("class_id", int'(class_id), eid);
        check("confidence", int'(confidence), econf);
        @(posedge clk); #1;
        check("done_pulse_width", int'(classification_done), 0);
        check("busy_idle", int'(busy), 0);
        last_id = eid;
        last_conf = econf;
    endtask

    initial begin
        int s[4];
        int eid, econf, sh, mode;

        tbl[0] = '{100, -20, 300, 50, 0, 2, 200};
        tbl[1] = '{500, 500, 0, 0, 0, 0, 0};
        tbl[2] = '{-32768, 32767, 0, 0, 3, 1, 255};
        tbl[3] = '{10, 20, 30, 40, 1, 3, 5};
        tbl[4] = '{-5, -5, -5, -5, 2, 0, 0};
        tbl[5] = '{0, 0, 0, 1000, 2, 3, 250};
        tbl[6] = '{-32768, -32768, -32768, -32768, 0, 0, 0};
        tbl[7] = '{300, -30, 0, 0, 2, 0, 75};

        rst = 1'b1;
        score_valid = 1'b0;
        score_data = '0;
        score_last = 1'b0;
        conf_shift = '0;

        // Reset state
        #12;
        check("rst_ready", int'(score_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_class_id", int'(class_id), 0);
        check("rst_confidence", int'(confidence), 0);
        check("rst_done", int'(classification_done), 0);
        check("rst_err", int'(frame_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("ready_before_first_edge", int'(score_ready), 0);
        @(posedge clk); #1;
        check("ready_after_release", int'(score_ready), 1);

        // Table vectors
        for (int i = 0; i < 8; i++)
            run_frame(tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3, tbl[i].sh, tbl[i].id, tbl[i].conf);

        // Early score_last on the 2nd transfer
        run_frame(tbl[0].s0, tbl[0].s1, tbl[0].s2, tbl[0].s3, tbl[0].sh, tbl[0].id, tbl[0].conf);
        xfer(100, 1'b0);
        check("busy_mid_frame", int'(busy), 1);
        xfer(200, 1'b1);
        check("err_early_last", int'(frame_err), 1);
        check("err_busy", int'(busy), 0);
        check("err_keep_id", int'(class_id), last_id);
        check("err_keep_conf", int'(confidence), last_conf);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("err_pulse_width", int'(frame_err), 0);
            check("err_no_done", int'(classification_done), 0);
        end
        run_frame(tbl[3].s0, tbl[3].s1, tbl[3].s2, tbl[3].s3, tbl[3].sh, tbl[3].id, tbl[3].conf);

        // Missing score_last on the 4th transfer
        for (int k = 0; k < 4; k++) xfer(k * 7, 1'b0);
        check("err_missing_last", int'(frame_err), 1);
        check("err_missing_last_id", int'(class_id), last_id);
        @(posedge clk); #1;
        check("err_missing_no_done", int'(classification_done), 0);
        run_frame(tbl[7].s0, tbl[7].s1, tbl[7].s2, tbl[7].s3, tbl[7].sh, tbl[7].id, tbl[7].conf);

        // Reset after 3 transfers
        run_frame(tbl[5].s0, tbl[5].s1, tbl[5].s2, tbl[5].s3, tbl[5].sh, tbl[5].id, tbl[5].conf);
        xfer(1000, 1'b0);
        xfer(2000, 1'b0);
        xfer(3000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_class_id", int'(class_id), 0);
        check("midrst_confidence", int'(confidence), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(score_ready), 0);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(tbl[0].s0, tbl[0].s1, tbl[0].s2, tbl[0].s3, tbl[0].sh, tbl[0].id, tbl[0].conf);

        // Back-to-back frames: one frame per 6 cycles
        done_times.delete();
        conf_shift = 2'd0;
        xfer(100, 1'b0); xfer(-20, 1'b0); xfer(300, 1'b0); xfer(50, 1'b1);
        xfer(5, 1'b0);   xfer(60, 1'b0);  xfer(7, 1'b0);   xfer(9, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_done_count", done_times.size(), 2);
        if (done_times.size() == 2) check("b2b_spacing", done_times[1] - done_times[0], 6);
        check("b2b_class_id", int'(class_id), 1);
        check("b2b_confidence", int'(confidence), 51);
        @(posedge clk); #1;

`ifdef DECISION_TIMEOUT_EN
        // Idle timeout aborts a partial frame
        xfer(7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("to_no_err_yet", int'(frame_err), 0);
        check("to_busy_yet", int'(busy), 1);
        @(posedge clk); #1;
        check("to_err", int'(frame_err), 1);
        check("to_busy_clear", int'(busy), 0);
        run_frame(tbl[2].s0, tbl[2].s1, tbl[2].s2, tbl[2].s3, tbl[2].sh, tbl[2].id, tbl[2].conf);
`else
        // Partial frame waits indefinitely
        conf_shift = 2'd1;
        xfer(10, 1'b0);
        repeat (300) begin
            @(posedge clk); #1;
            if (frame_err) check("wait_no_err", int'(frame_err), 0);
        end
        check("wait_busy", int'(busy), 1);
        xfer(20, 1'b0);
        xfer(30, 1'b0);
        xfer(40, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wait_done", int'(classification_done), 1);
        check("wait_class_id", int'(class_id), 3);
        check("wait_confidence", int'(confidence), 5);
        @(posedge clk); #1;
`endif

        // Randomized frames against the reference model
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 4; i++) begin
                mode = int'($urandom_range(0, 2));
                if (mode == 0) s[i] = int'($signed(16'($urandom)));
                else if (mode == 1) s[i] = int'($urandom_range(0, 6)) - 3;
                else begin
                    case ($urandom_range(0, 2))
                        0: s[i] = -32768;
                        1: s[i] = 32767;
                        default: s[i] = 0;
                    endcase
                end
            end
            sh = int'($urandom_range(0, 3));
            model(s, sh, eid, econf);
            run_frame(s[0], s[1], s[2], s[3], sh, eid, econf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/class_decision.md
CLASS_DECISION -- requirements
Module: class_decision

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: idle cycles allowed mid-frame before abort (used only with DECISION_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port score_valid  input  1  score_data is valid this cycle.
REQ-005 SHALL have port score_ready  output  1  block can accept a score this cycle.
REQ-006 SHALL have port score_data  input  16  signed two's-complement class score.
REQ-007 SHALL have port score_last  input  1  marks the final score of a frame.
REQ-008 SHALL have port conf_shift  input  2  right-shift applied to the top-1/top-2 margin.
REQ-009 SHALL have port classification_done  output  1  single-cycle pulse; result outputs are valid.
REQ-010 SHALL have port class_id  output  2  index of the winning class.
REQ-011 SHALL have port confidence  output  8  saturated margin, scaled by conf_shift.
REQ-012 SHALL have port frame_err  output  1  single-cycle pulse; the frame was discarded.
REQ-013 SHALL have port busy  output  1  high while a frame is partially received or being resolved.

Function
REQ-014 SHALL accept a score on any cycle where score_valid && score_ready are both high (a transfer).
REQ-015 SHALL treat each frame as exactly 4 transfers, in class order 0,1,2,3; an internal 2-bit index counts transfers.
REQ-016 SHALL use states ACCUM, RESOLVE, DONE; after reset the state is ACCUM with index 0.
REQ-017 SHALL, in ACCUM at index 0, load max=score, second=-32768, best_idx=0.
REQ-018 SHALL, in ACCUM at index>0, update on a strict compare:
- if score>max: second=max, max=score, best_idx=index;
- else if score>second: second=score.
REQ-019 SHALL resolve ties in favour of the lower class index.
REQ-020 SHALL, on a transfer at index 3 with score_last=1, update the trackers and move to RESOLVE.
REQ-021 SHALL, on a transfer with score_last=1 at index<3, or score_last=0 at index 3:
- discard the frame and pulse frame_err the next cycle;
- reset index to 0 and stay in ACCUM;
- hold class_id and confidence unchanged.
REQ-022 SHALL drive score_ready=1 only in ACCUM, and 0 in RESOLVE and DONE.
REQ-023 SHALL, in RESOLVE, compute margin = max - second as a 17-bit unsigned value (range 0..65535).
REQ-024 SHALL compute confidence as margin >> conf_shift, saturated to 255, and register class_id=best_idx; then move to DONE.
REQ-025 SHALL sample conf_shift only in RESOLVE.
REQ-026 SHALL, in DONE, pulse classification_done for exactly one cycle, then return to ACCUM with index 0.
REQ-027 SHALL give a latency of 2 cycles from the final transfer edge to classification_done high.
REQ-028 SHALL hold class_id and confidence stable from classification_done until the next classification_done.
REQ-029 SHALL drive busy=1 when index>0 or the state is RESOLVE or DONE.
REQ-030 SHALL sustain a maximum throughput of one frame per 6 cycles.

Reset
REQ-031 SHALL, on rst asserted at any time including mid-frame, immediately clear all of the following without waiting for a clock edge:
- state=ACCUM, index=0, max=0, second=0, best_idx=0;
- classification_done=0, frame_err=0, class_id=0, confidence=0, busy=0, score_ready=0.
REQ-032 SHALL hold score_ready=0 while rst is high; it rises the first cycle after release.

Configuration
REQ-033 SHALL, with macro DECISION_TIMEOUT_EN defined, include an 8-bit idle counter:
- the counter runs in ACCUM while index>0 and clears on every transfer;
- when it reaches TIMEOUT_CYCLES, the frame is discarded exactly as in REQ-021 (frame_err pulse, index=0).
REQ-034 SHALL, with DECISION_TIMEOUT_EN undefined, omit the counter entirely; a partial frame then waits indefinitely.

Verification
REQ-035 Scores 100,-20,300,50, last on the 4th -> class_id=2, confidence=200, done exactly 2 cycles after the 4th transfer.
REQ-036 Scores 500,500,0,0, conf_shift=0 -> class_id=0 (tie to lower index), confidence=0.
REQ-037 Scores -32768,32767,0,0, conf_shift=3 -> margin 32767, shifted 4095, confidence=255 (saturated), class_id=1.
REQ-038 score_last on the 2nd transfer -> frame_err pulses once, no done, prior class_id/confidence retained; the next clean frame resolves correctly.
REQ-039 rst pulsed after 3 transfers -> outputs zero immediately; the following 4-score frame decodes with no carryover.
REQ-040 With DECISION_TIMEOUT_EN and TIMEOUT_CYCLES=10: 1 transfer, then 10 idle cycles -> frame_err pulse, busy=0, index restarts at 0.
